aud_i2s_capture: RTL and testbench
==================================

// Module: aud_i2s_capture
// PURPOSE
//  Parametrised I2S capture engine: next-generation audio recorder front end. Deserialises the
//  codec ADC/loopback bit stream into DATA_W-bit words for one or both channels, selectable
//  I2S (1-bit delay) or left-justified framing. Generates sequential SRAM word addresses with
//  start/pause/stop control and a capacity limit. Sits between the codec pins and the SRAM writer.
// PARAMETERS
//  DATA_W    16       sample width in bits (8..32); extra bits in a half-frame are ignored
//  ADDR_W    20       width of SRAM word address
//  ADDR_MAX  2**20-1  last writable address; capture halts after writing this address
//  STEREO    1        1: capture left and right; 0: capture left (lrck=0) only
// PORTS
//  i_clk       in   1       codec bit clock (BCLK); all logic on posedge
//  i_rst_n     in   1       asynchronous active-low reset
//  i_lrck      in   1       channel clock, 0=left 1=right, changes synchronously to i_clk
//  i_data      in   1       serial audio data, MSB first
//  i_lj        in   1       0: I2S framing, 1: left-justified; sampled only in ARMED
//  i_start     in   1       level/pulse: IDLE->ARMED (clears address), PAUSED->ARMED (keeps address)
//  i_pause     in   1       ARMED/CAPTURE -> PAUSED
//  i_stop      in   1       any state -> IDLE
//  o_data      out  DATA_W  last completed sample
//  o_channel   out  1       channel of o_data (0=left)
//  o_address   out  ADDR_W  SRAM address for o_data; valid with o_valid
//  o_valid     out  1       one-cycle strobe: o_data/o_channel/o_address new
//  o_short     out  1       one-cycle strobe: half-frame ended before DATA_W bits received
//  o_full      out  1       high after ADDR_MAX written; cleared by start from IDLE
//  o_state     out  2       current FSM state (encoding in aud_pkg)
// BEHAVIOUR
//  - Reset (async): all outputs 0, FSM IDLE, address counter 0, shift reg/bit counter 0.
//  - Edge detect: lrck_d <= i_lrck each cycle; edge = i_lrck != lrck_d. Runs in every state.
//  - FSM: IDLE, ARMED, CAPTURE, PAUSED. Priority when simultaneous: stop > pause > start.
//    IDLE   -start-> ARMED, addr_cnt<=0, o_full<=0.
//    ARMED  -edge to a captured channel-> CAPTURE; latch i_lj as mode for the session.
//    CAPTURE-pause-> PAUSED (partial word discarded); -stop-> IDLE (addr_cnt held, readable).
//    PAUSED -start-> ARMED, addr_cnt kept.
//  - Bit timing: LJ: MSB sampled in the edge cycle. I2S: edge cycle is the delay slot; MSB sampled
//    the following cycle. Subsequent bits one per cycle; bits beyond DATA_W ignored until next edge.
//  - STEREO=0: right half-frames (i_lrck=1) ignored, no strobes; o_channel always 0.
//  - Word complete (DATA_W-th bit sampled): next cycle o_valid=1, o_data=word, o_channel=channel
//    of that half-frame, o_address=addr_cnt; addr_cnt increments same edge. Latency 1 cycle after
//    last bit. o_data/o_channel/o_address hold until next word.
//  - Short half-frame: edge while in CAPTURE with bit count in 1..DATA_W-1 -> o_short pulse,
//    word dropped, new half-frame starts normally on this edge.
//  - Capacity: word written at ADDR_MAX -> o_full<=1, FSM->IDLE same cycle as o_valid; no wrap.
//  - Stop/pause mid-word never produce o_valid. Reset mid-capture: immediate return to reset values.
// STRUCTURE
//  - aud_pkg: typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_PAUSED} aud_cap_state_e;
//    framing constants FRAME_I2S=1'b0, FRAME_LJ=1'b1; channel constants CH_L/CH_R.
//  - Sub-module aud_i2s_deser #(DATA_W): edge detect, delay slot, bit counter, shift register;
//    outputs word/word_done/short/channel. Top holds FSM, address counter, output registers.
// TESTING (DATA_W=16, BCLK 10 ns, LRCK half-period 36 BCLK unless stated)
//  1 I2S, STEREO=1: serialiser sends L=16'h1111, R=16'hA5C3 -> o_valid x2: (1111,ch0,addr0), (A5C3,ch1,addr1).
//  2 LJ, same words with MSB at LRCK edge -> identical o_data; I2S-framed input to LJ DUT -> 16'h0888/16'h52E1.
//  3 STEREO=0, 4 frames L=0001..0004 -> 4 o_valid, addr 0..3, o_channel=0, nothing on right halves.
//  4 Pause at bit 7 of word at addr 5 -> no o_valid; start -> next word written at addr 5.
//  5 ADDR_MAX=3: 4 words -> o_full=1, o_state=IDLE, no further o_valid; start -> o_full=0, addr 0.
//  6 LRCK half-period 10 -> o_short each half, no o_valid; async reset mid-word -> all outputs 0 at once.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S capture front end.
package aud_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_PAUSED  = 2'd3
    } aud_cap_state_e;

    localparam logic FRAME_I2S = 1'b0;
    localparam logic FRAME_LJ  = 1'b1;
    localparam logic CH_L      = 1'b0;
    localparam logic CH_R      = 1'b1;

endpackage

// File: rtl/aud_i2s_deser.sv
// Serial-to-parallel half-frame deserialiser with LRCK edge detect.
module aud_i2s_deser
    import aud_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int STEREO = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrck,
    input  logic              i_data,
    input  logic              i_run,
    input  logic              i_lj,
    output logic              o_start,
    output logic              o_done,
    output logic              o_short,
    output logic              o_channel,
    output logic [DATA_W-1:0] o_word
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              r_lrck_d;
    logic              r_act;
    logic              r_ch;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-2:0] r_sreg;

    logic w_edge;
    logic w_take;
    logic w_shift;

    assign w_edge  = i_lrck != r_lrck_d;
    assign w_take  = (STEREO != 0) || (i_lrck == CH_L);
    assign w_shift = i_run && !w_edge && r_act && (r_cnt < CNT_W'(DATA_W));

    assign o_start   = i_run && w_edge && w_take;
    assign o_done    = w_shift && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_short   = i_run && w_edge && r_act && (r_cnt != '0)
                     && (r_cnt < CNT_W'(DATA_W));
    assign o_channel = r_ch;
    assign o_word    = {r_sreg, i_data};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lrck_d <= 1'b0;
            r_act    <= 1'b0;
            r_ch     <= 1'b0;
            r_cnt    <= '0;
            r_sreg   <= '0;
        end else begin
            r_lrck_d <= i_lrck;
            if (!i_run) begin
                r_act <= 1'b0;
                r_cnt <= '0;
            end else if (w_edge) begin
                // LJ samples the MSB on the edge; I2S spends it as the delay slot
                r_act <= w_take;
                if (w_take) begin
                    r_ch <= i_lrck;
                end
                if (w_take && i_lj == FRAME_LJ) begin
                    r_sreg <= {{(DATA_W - 2){1'b0}}, i_data};
                    r_cnt  <= CNT_W'(1);
                end else begin
                    r_cnt <= '0;
                end
            end else if (w_shift) begin
                r_sreg <= o_word[DATA_W-2:0];
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/aud_i2s_capture.sv
// I2S / left-justified capture engine: session FSM, SRAM address
// generation and output registers around the deserialiser.
module aud_i2s_capture
    import aud_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}},
    parameter int                STEREO   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrck,
    input  logic              i_data,
    input  logic              i_lj,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_channel,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_valid,
    output logic              o_short,
    output logic              o_full,
    output logic [1:0]        o_state
);

    aud_cap_state_e    r_state;
    logic              r_mode;
    logic [ADDR_W-1:0] r_addr;

    logic              w_run;
    logic              w_mode;
    logic              w_start;
    logic              w_done;
    logic              w_short;
    logic              w_ch;
    logic [DATA_W-1:0] w_word;
    logic              w_wr;
    logic              w_last;

    // a pause or stop in the same cycle discards whatever is in flight
    assign w_run  = (r_state == S_ARMED || r_state == S_CAPTURE)
                  && !i_stop && !i_pause;
    assign w_mode = (r_state == S_ARMED) ? i_lj : r_mode;
    assign w_wr   = w_done && (r_state == S_CAPTURE);
    assign w_last = r_addr == ADDR_MAX;

    assign o_state = r_state;

    aud_i2s_deser #(
        .DATA_W (DATA_W),
        .STEREO (STEREO)
    ) u_deser (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_lrck    (i_lrck),
        .i_data    (i_data),
        .i_run     (w_run),
        .i_lj      (w_mode),
        .o_start   (w_start),
        .o_done    (w_done),
        .o_short   (w_short),
        .o_channel (w_ch),
        .o_word    (w_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= FRAME_I2S;
            r_addr    <= '0;
            o_data    <= '0;
            o_channel <= 1'b0;
            o_address <= '0;
            o_valid   <= 1'b0;
            o_short   <= 1'b0;
            o_full    <= 1'b0;
        end else begin
            o_valid <= w_wr;
            o_short <= w_short && (r_state == S_CAPTURE);
            if (w_wr) begin
                o_data    <= w_word;
                o_channel <= w_ch;
                o_address <= r_addr;
                if (w_last) begin
                    o_full <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
            unique case (r_state)
                S_IDLE: begin
                    if (!i_stop && i_start) begin
                        r_state <= S_ARMED;
                        r_addr  <= '0;
                        o_full  <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (i_pause) begin
                        r_state <= S_PAUSED;
                    end else if (w_start) begin
                        r_state <= S_CAPTURE;
                        r_mode  <= i_lj;
                    end
                end
                S_CAPTURE: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (i_pause) begin
                        r_state <= S_PAUSED;
                    end else if (w_wr && w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                S_PAUSED: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (i_start) begin
                        r_state <= S_ARMED;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aud_i2s_capture.sv
// Bench: three DUT configurations (stereo, mono, ADDR_MAX=3) on one serial bus,
// checked against a bit-stream reference model.
module tb_aud_i2s_capture;
    import aud_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic        ch;
        logic [19:0] a;
        int          cyc;
    } ent_t;

    typedef struct {
        int e;
        int len;
        bit ch;
    } half_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic lrck  = 1'b1;
    logic data  = 1'b0;
    logic lj    = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic stop  = 1'b0;

    logic [15:0] od  [3];
    logic        och [3];
    logic [19:0] oa  [3];
    logic        ov  [3];
    logic        osh [3];
    logic        ofl [3];
    logic [1:0]  ost [3];

    int stv  [3] = '{1, 0, 1};
    int amax [3] = '{1048575, 1048575, 3};

    ent_t  obs [3][$];
    ent_t  ex [$];
    int    nsh [3];
    half_t halves [$];
    bit    stream [int];
    int    cyc = 0;
    int    checks = 0;
    int    passes = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aud_i2s_capture #(
            .DATA_W   (16),
            .ADDR_W   (20),
            .ADDR_MAX (g == 2 ? 20'd3 : 20'hFFFFF),
            .STEREO   (g == 1 ? 0 : 1)
        ) u_dut (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_lrck    (lrck),
            .i_data    (data),
            .i_lj      (lj),
            .i_start   (start),
            .i_pause   (pause),
            .i_stop    (stop),
            .o_data    (od[g]),
            .o_channel (och[g]),
            .o_address (oa[g]),
            .o_valid   (ov[g]),
            .o_short   (osh[g]),
            .o_full    (ofl[g]),
            .o_state   (ost[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ov[k] === 1'b1) obs[k].push_back('{od[k], och[k], oa[k], cyc});
            if (osh[k] === 1'b1) nsh[k]++;
        end
    end

    // Reference: a captured half-frame yields the 16 stream bits starting at
    // its edge (LJ) or one cycle later (I2S); addresses are sequential up to amax.
    function automatic void model(int k, bit mlj, int h0, int h1, int base);
        int a;
        int off;
        logic [15:0] w;
        a = base;
        off = mlj ? 0 : 1;
        for (int h = h0; h < h1; h++) begin
            if (a > amax[k]) break;
            if (stv[k] == 0 && halves[h].ch) continue;
            if (off + 16 > halves[h].len) continue;
            for (int b = 0; b < 16; b++) w[15-b] = stream[halves[h].e + off + b];
            ex.push_back('{w, halves[h].ch, a[19:0], halves[h].e + off + 15});
            a++;
        end
    endfunction

    task automatic drive_half(bit ch, logic [15:0] w, bit ljf, int len,
                              bit prand, int pause_at);
        int b;
        for (int i = 0; i < len; i++) begin
            b = ljf ? i : i - 1;
            @(negedge clk);
            lrck  = ch;
            start = 1'b0;
            stop  = 1'b0;
            pause = (pause_at >= 0 && b == pause_at);
            if (b >= 0 && b < 16) data = w[15-b];
            else data = prand ? 1'($urandom_range(1)) : 1'b0;
            stream[cyc + 1] = data;
            if (i == 0) halves.push_back('{cyc + 1, len, ch});
        end
    endtask

    task automatic gap(int n, bit st, bit sp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = st && (i == 1);
            stop  = sp && (i == 0);
            pause = 1'b0;
            data  = 1'($urandom_range(1));
            stream[cyc + 1] = data;
        end
    endtask

    task automatic frame(logic [15:0] l, logic [15:0] r, bit ljf, bit prand);
        drive_half(1'b0, l, ljf, 36, prand, -1);
        drive_half(1'b1, r, ljf, 36, prand, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lrck = 1'b1; data = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            obs[k].delete();
            nsh[k] = 0;
        end
        halves.delete();
        gap(2, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({od[k], och[k], oa[k], ov[k], osh[k], ofl[k], ost[k]} !== '0)
                $display("FAIL reset dut%0d got d=%h ch=%b a=%0d v=%b s=%b f=%b st=%0d want all 0",
                         k, od[k], och[k], oa[k], ov[k], osh[k], ofl[k], ost[k]);
            else passes++;
        end
    endtask

    task automatic test_i2s_basic();
        do_reset();
        lj = FRAME_I2S;
        gap(3, 1'b1, 1'b0);
        frame(16'h1111, 16'hA5C3, 1'b0, 1'b1);
        gap(4, 1'b0, 1'b0);
        checks++;
        if (ost[0] !== S_CAPTURE) $display("FAIL i2s_state got %0d want %0d", ost[0], S_CAPTURE);
        else passes++;
        for (int k = 0; k < 3; k++) begin
            ex.delete();
            model(k, 1'b0, 0, 2, 0);
            checks++;
            if (obs[k].size() != ex.size())
                $display("FAIL i2s_count dut%0d got %0d want %0d", k, obs[k].size(), ex.size());
            else passes++;
            for (int i = 0; i < ex.size() && i < obs[k].size(); i++) begin
                checks++;
                if (obs[k][i] !== ex[i])
                    $display("FAIL i2s_word dut%0d #%0d got %h/%0d/%0d@%0d want %h/%0d/%0d@%0d", k, i,
                             obs[k][i].d, obs[k][i].ch, obs[k][i].a, obs[k][i].cyc,
                             ex[i].d, ex[i].ch, ex[i].a, ex[i].cyc);
                else passes++;
            end
        end
    endtask

    task automatic test_lj();
        do_reset();
        lj = FRAME_LJ;
        gap(3, 1'b1, 1'b0);
        frame(16'h1111, 16'hA5C3, 1'b1, 1'b1);
        gap(4, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            ex.delete();
            model(k, 1'b1, 0, 2, 0);
            checks++;
            if (obs[k].size() != ex.size())
                $display("FAIL lj_count dut%0d got %0d want %0d", k, obs[k].size(), ex.size());
            else passes++;
            for (int i = 0; i < ex.size() && i < obs[k].size(); i++) begin
                checks++;
                if (obs[k][i] !== ex[i])
                    $display("FAIL lj_word dut%0d #%0d got %h/%0d/%0d@%0d want %h/%0d/%0d@%0d", k, i,
                             obs[k][i].d, obs[k][i].ch, obs[k][i].a, obs[k][i].cyc,
                             ex[i].d, ex[i].ch, ex[i].a, ex[i].cyc);
                else passes++;
            end
        end
        // I2S-framed bits into an LJ session: every word appears shifted right by one
        do_reset();
        lj = FRAME_LJ;
        gap(3, 1'b1, 1'b0);
        frame(16'h1111, 16'hA5C3, 1'b0, 1'b0);
        gap(4, 1'b0, 1'b0);
        checks++;
        if (obs[0].size() != 2) $display("FAIL lj_cross_count got %0d want 2", obs[0].size());
        else passes++;
        checks++;
        if (obs[0][0].d !== 16'h0888) $display("FAIL lj_cross_l got %h want 0888", obs[0][0].d);
        else passes++;
        checks++;
        if (obs[0][1].d !== 16'h52E1) $display("FAIL lj_cross_r got %h want 52e1", obs[0][1].d);
        else passes++;
    endtask

    task automatic test_stream_capacity();
        bit mlj;
        do_reset();
        mlj = 1'($urandom_range(1));
        lj = mlj;
        gap(3, 1'b1, 1'b0);
        for (int f = 0; f < 6; f++)
            frame(16'($urandom), 16'($urandom), mlj, 1'b1);
        gap(3, 1'b0, 1'b0);
        checks++;
        if (ofl[2] !== 1'b1 || ost[2] !== S_IDLE || oa[2] !== 20'd3)
            $display("FAIL cap_full got f=%b st=%0d a=%0d want f=1 st=0 a=3", ofl[2], ost[2], oa[2]);
        else passes++;
        gap(3, 1'b1, 1'b0);
        checks++;
        if (ofl[2] !== 1'b0 || ost[2] !== S_ARMED)
            $display("FAIL cap_restart got f=%b st=%0d want f=0 st=1", ofl[2], ost[2]);
        else passes++;
        frame(16'($urandom), 16'($urandom), mlj, 1'b1);
        gap(4, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            ex.delete();
            model(k, mlj, 0, 12, 0);
            model(k, mlj, 12, 14, (k == 2) ? 0 : ex.size());
            checks++;
            if (obs[k].size() != ex.size())
                $display("FAIL stream_count dut%0d got %0d want %0d", k, obs[k].size(), ex.size());
            else passes++;
            for (int i = 0; i < ex.size() && i < obs[k].size(); i++) begin
                checks++;
                if (obs[k][i] !== ex[i])
                    $display("FAIL stream_word dut%0d #%0d got %h/%0d/%0d@%0d want %h/%0d/%0d@%0d", k, i,
                             obs[k][i].d, obs[k][i].ch, obs[k][i].a, obs[k][i].cyc,
                             ex[i].d, ex[i].ch, ex[i].a, ex[i].cyc);
                else passes++;
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        lj = FRAME_I2S;
        gap(3, 1'b1, 1'b0);
        frame(16'($urandom), 16'($urandom), 1'b0, 1'b1);
        frame(16'($urandom), 16'($urandom), 1'b0, 1'b1);
        drive_half(1'b0, 16'($urandom), 1'b0, 36, 1'b1, -1);
        drive_half(1'b1, 16'($urandom), 1'b0, 36, 1'b1, 7);
        checks++;
        if (ost[0] !== S_PAUSED || ost[1] !== S_PAUSED)
            $display("FAIL pause_state got %0d/%0d want 3/3", ost[0], ost[1]);
        else passes++;
        gap(3, 1'b1, 1'b0);
        checks++;
        if (ost[0] !== S_ARMED) $display("FAIL resume_state got %0d want 1", ost[0]);
        else passes++;
        frame(16'($urandom), 16'($urandom), 1'b0, 1'b1);
        gap(4, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            ex.delete();
            model(k, 1'b0, 0, 5, 0);
            model(k, 1'b0, 6, 8, (k == 2) ? 0 : ex.size());
            checks++;
            if (obs[k].size() != ex.size())
                $display("FAIL pause_count dut%0d got %0d want %0d", k, obs[k].size(), ex.size());
            else passes++;
            for (int i = 0; i < ex.size() && i < obs[k].size(); i++) begin
                checks++;
                if (obs[k][i] !== ex[i])
                    $display("FAIL pause_word dut%0d #%0d got %h/%0d/%0d@%0d want %h/%0d/%0d@%0d", k, i,
                             obs[k][i].d, obs[k][i].ch, obs[k][i].a, obs[k][i].cyc,
                             ex[i].d, ex[i].ch, ex[i].a, ex[i].cyc);
                else passes++;
            end
        end
    endtask

    task automatic test_short();
        int want;
        do_reset();
        lj = FRAME_I2S;
        gap(3, 1'b1, 1'b0);
        for (int h = 0; h < 4; h++)
            drive_half(h[0], 16'($urandom), 1'b0, 10, 1'b1, -1);
        gap(3, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            want = 0;
            for (int h = 0; h < 3; h++)
                if ((stv[k] != 0 || !halves[h].ch) && halves[h].len - 1 >= 1
                    && halves[h].len - 1 < 16) want++;
            checks++;
            if (nsh[k] != want || obs[k].size() != 0 || ost[k] !== S_IDLE)
                $display("FAIL short dut%0d got sh=%0d v=%0d st=%0d want sh=%0d v=0 st=0",
                         k, nsh[k], obs[k].size(), ost[k], want);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] rw;
        do_reset();
        lj = FRAME_I2S;
        gap(3, 1'b1, 1'b0);
        rw = 16'($urandom);
        frame(16'($urandom), rw, 1'b0, 1'b1);
        drive_half(1'b0, 16'($urandom), 1'b0, 6, 1'b1, -1);
        checks++;
        if (od[0] !== rw || oa[0] !== 20'd1 || och[0] !== 1'b1)
            $display("FAIL prereset got %h/%0d/%0d want %h/1/1", od[0], oa[0], och[0], rw);
        else passes++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({od[k], och[k], oa[k], ov[k], osh[k], ofl[k], ost[k]} !== '0)
                $display("FAIL async_reset dut%0d got d=%h a=%0d st=%0d want all 0",
                         k, od[k], oa[k], ost[k]);
            else passes++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i2s_basic();
        test_lj();
        test_stream_capacity();
        test_pause();
        test_short();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
